// File: rtl/pc_fetch_ctrl.sv
// FRiscV PC sequencer and imem fetch handshake; decode gets one buffered word.
// Optional: define FRISCV_PC_MISALIGN_EN to halt on misaligned redirect targets.
module pc_fetch_ctrl #(
  parameter int              ARCH       = 32,
  parameter int              ARCH_BYTES = ARCH / 8,
  parameter logic [ARCH-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_taken_i,
  input  logic [ARCH-1:0] branch_target_i,
  input  logic            trap_i,
  input  logic [ARCH-1:0] trap_vec_i,
  output logic            imem_req_o,
  output logic [ARCH-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [ARCH-1:0] instr_pc_o,
  output logic [ARCH-1:0] pc_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef FRISCV_PC_MISALIGN_EN
    , S_HALT
`endif
  } state_e;

  state_e          state_q;
  logic [ARCH-1:0] pc_q;
  logic            req_q;
  logic            valid_q;
  logic [31:0]     instr_q;
  logic [ARCH-1:0] ipc_q;
  logic            discard_q;

  logic            redir;
  logic [ARCH-1:0] tgt_raw;
  logic [ARCH-1:0] tgt;
  logic [ARCH-1:0] pc_inc;

  assign redir   = trap_i | branch_taken_i;
  assign tgt_raw = trap_i ? trap_vec_i : branch_target_i;
  assign pc_inc  = pc_q + ARCH'(ARCH_BYTES);

`ifdef FRISCV_PC_MISALIGN_EN
  logic misalign_q;
  logic tgt_mis;
  logic vec_mis;
  logic in_flight;

  assign tgt       = tgt_raw;
  assign tgt_mis   = |tgt_raw[1:0];
  assign vec_mis   = |trap_vec_i[1:0];
  // a granted request whose response has not come back yet
  assign in_flight = (state_q == S_REQ && req_q && imem_gnt_i)
                   | (state_q == S_WAIT && !imem_rvalid_i);
  assign misalign_o = misalign_q;
`else
  assign tgt        = tgt_raw & ~ARCH'(3);
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_ADDR;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      ipc_q     <= '0;
      discard_q <= 1'b0;
`ifdef FRISCV_PC_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef FRISCV_PC_MISALIGN_EN
      if (state_q != S_HALT && redir && tgt_mis) begin
        pc_q       <= tgt;
        misalign_q <= 1'b1;
        req_q      <= 1'b0;
        valid_q    <= 1'b0;
        discard_q  <= in_flight;
        state_q    <= S_HALT;
      end else
`endif
      unique case (state_q)
        S_REQ: begin
`ifdef FRISCV_PC_MISALIGN_EN
          if (imem_rvalid_i) discard_q <= 1'b0;
`endif
          if (req_q && imem_gnt_i) begin
            req_q     <= 1'b0;
            discard_q <= redir;
            state_q   <= S_WAIT;
          end else begin
            req_q <= 1'b1;
          end
          if (redir) pc_q <= tgt;
        end
        S_WAIT: begin
          if (redir) begin
            pc_q <= tgt;
            if (imem_rvalid_i) begin
              discard_q <= 1'b0;
              req_q     <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (imem_rvalid_i) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              req_q     <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              instr_q <= imem_rdata_i;
              ipc_q   <= pc_q;
              pc_q    <= pc_inc;
              valid_q <= 1'b1;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redir) pc_q <= tgt;
          if (redir || instr_ready_i) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
`ifdef FRISCV_PC_MISALIGN_EN
        S_HALT: begin
          if (imem_rvalid_i) discard_q <= 1'b0;
          if (trap_i) begin
            pc_q <= trap_vec_i;
            if (!vec_mis) begin
              misalign_q <= 1'b0;
              req_q      <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
`endif
        default: begin
          req_q   <= 1'b0;
          state_q <= S_REQ;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: random imem timing, ready and redirects.
// Model tracks the PC of the next instruction decode must receive.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_vec_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_o;
  logic        misalign_o;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .trap_i         (trap_i),
    .trap_vec_i     (trap_vec_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .pc_o           (pc_o),
    .misalign_o     (misalign_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];

  int  p_gnt = 100;
  int  p_rdy = 100;
  int  max_dly = 0;

  bit          granted = 0;
  logic [31:0] gaddr = '0;
  int          gcount = 0;
  bit          pend = 0;
  logic [31:0] paddr = '0;
  int          dly = 0;
  bit          cur_redir = 0;

  int  ndeliv = 0;
  time last_xfer_t = 0;
  time prev_xfer_t = 0;
  int  idle = 0;

  bit          pv_valid = 0;
  bit          pv_xfer = 0;
  bit          pv_redir = 0;
  logic [31:0] pv_instr = '0;
  logic [31:0] pv_pc = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every decode transfer
  always @(negedge clk) begin
    if (rst_n) begin
      granted = imem_req_o && imem_gnt_i;
      if (granted) begin
        gaddr = imem_addr_o;
        gcount++;
      end
      if (pv_valid && !pv_xfer && !pv_redir) begin
        chk("hold_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("hold_instr", instr_o, pv_instr);
        chk("hold_pc", instr_pc_o, pv_pc);
        chk("hold_noreq", {31'd0, imem_req_o}, 32'd0);
      end
      if (instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_xfer: got pc %h expected none",
                   instr_pc_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc_o, e);
          chk("instr", instr_o, mem(e));
        end
        ndeliv++;
        prev_xfer_t = last_xfer_t;
        last_xfer_t = $time;
        idle = 0;
      end else begin
        idle++;
        if (idle == 300) begin
          miscompares++;
          $display("FAIL stall: got no transfer for %0d cycles expected progress",
                   idle);
        end
      end
      pv_valid = instr_valid_o;
      pv_xfer  = instr_valid_o && instr_ready_i;
      pv_redir = cur_redir;
      pv_instr = instr_o;
      pv_pc    = instr_pc_o;
    end
  end

  task automatic step(input logic br, input logic [31:0] bt,
                      input logic tr, input logic [31:0] tv);
    logic [31:0] t;
    bit xfer;
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    if (granted) begin
      pend  = 1;
      paddr = gaddr;
      dly   = $urandom_range(0, max_dly);
    end
    if (pend) begin
      if (dly == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem(paddr);
        pend = 0;
      end else begin
        dly--;
      end
    end
    imem_gnt_i = imem_req_o && ($urandom_range(0, 99) < p_gnt);
    instr_ready_i = $urandom_range(0, 99) < p_rdy;
    branch_taken_i  = br;
    branch_target_i = bt;
    trap_i          = tr;
    trap_vec_i      = tv;
    cur_redir = br | tr;
    xfer = instr_valid_o && instr_ready_i;
    t = tr ? tv : bt;
`ifndef FRISCV_PC_MISALIGN_EN
    t[1:0] = 2'b00;
`endif
    if (br || tr) begin
      if (xfer && exp_q.size() > 0) begin
        while (exp_q.size() > 1) void'(exp_q.pop_back());
      end else begin
        exp_q.delete();
      end
      exp_q.push_back(t);
    end else if (xfer && exp_q.size() > 0) begin
      exp_q.push_back(exp_q[0] + 32'd4);
    end
  endtask

  task automatic redirect(input logic br, input logic [31:0] bt,
                          input logic tr, input logic [31:0] tv);
    int sv;
    sv = p_gnt;
    p_gnt = 0;
    step(br, bt, tr, tv);
    p_gnt = sv;
    step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic run_deliv(input int n);
    int tgt;
    int k;
    tgt = ndeliv + n;
    k = 0;
    while (ndeliv < tgt && k < 200) begin
      step(1'b0, '0, 1'b0, '0);
      k++;
    end
    if (ndeliv < tgt) begin
      miscompares++;
      $display("FAIL deliv_timeout: got %0d expected %0d", ndeliv, tgt);
    end
  endtask

  task automatic wait_grant(output logic [31:0] a);
    int g0;
    int k;
    g0 = gcount;
    k = 0;
    while (gcount == g0 && k < 200) begin
      step(1'b0, '0, 1'b0, '0);
      k++;
    end
    if (gcount == g0) begin
      miscompares++;
      $display("FAIL grant_timeout: got none expected a grant");
    end
    a = gaddr;
  endtask

  initial begin
    logic [31:0] a;
    exp_q.push_back(32'h0);
    #12;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_ipc", instr_pc_o, 32'h0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, '0);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);

    run_deliv(2);
    chk("throughput", 32'(last_xfer_t - prev_xfer_t), 32'd30);
    wait_grant(a);
    chk("fetch8_addr", a, 32'h8);
    step(1'b1, 32'h40, 1'b0, '0);
    wait_grant(a);
    chk("br_addr", a, 32'h40);
    run_deliv(1);

    p_rdy = 0;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, '0);
    chk("held_valid", {31'd0, instr_valid_o}, 32'd1);
    p_rdy = 100;

    redirect(1'b1, 32'h40, 1'b1, 32'h100);
    wait_grant(a);
    chk("trap_wins", a, 32'h100);
    run_deliv(1);

    redirect(1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    run_deliv(1);
    wait_grant(a);
    chk("wrap_addr", a, 32'h0);
    run_deliv(1);

    redirect(1'b1, 32'h42, 1'b0, '0);
`ifdef FRISCV_PC_MISALIGN_EN
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, '0);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_noreq", {31'd0, imem_req_o}, 32'd0);
    chk("mis_pc", pc_o, 32'h42);
    redirect(1'b0, '0, 1'b1, 32'h100);
    wait_grant(a);
    chk("mis_trap_addr", a, 32'h100);
    chk("mis_clear", {31'd0, misalign_o}, 32'd0);
`else
    wait_grant(a);
    chk("mask_addr", a, 32'h40);
    chk("mis_tied", {31'd0, misalign_o}, 32'd0);
`endif
    run_deliv(1);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] bt;
      logic [31:0] tv;
      int r;
      if (i % 250 == 0) begin
        p_gnt   = $urandom_range(30, 100);
        p_rdy   = $urandom_range(30, 100);
        max_dly = $urandom_range(0, 3);
      end
      bt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 1023));
      tv = 32'h100 + 32'($urandom_range(0, 63));
`ifdef FRISCV_PC_MISALIGN_EN
      bt[1:0] = 2'b00;
      tv[1:0] = 2'b00;
`endif
      r = $urandom_range(0, 19);
      step(r == 0 || r == 2, bt, r == 1 || r == 2, tv);
    end
    p_rdy = 100;
    run_deliv(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
